pi_mem_bridge: RTL and testbench

Downstream consumer of the SPI-side PI bus. It runs in the `sys_clk` domain and turns each byte access strobed by `pi_sync` into a 16-bit request/acknowledge transaction on the cartridge memory port. Read data goes back to the PI front end on `pi_din`. The block lets the host MCU read and write cart RAM/ROM byte-wise over SPI.

---
 rtl/pi_mem_bridge_pkg.sv | 31 +++
 rtl/pi_mem_bridge_rd_cache.sv | 47 ++++
 rtl/pi_mem_bridge.sv | 132 +++++++++++++
 tb/tb_pi_mem_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_mem_bridge_pkg.sv
// Shared definitions for the PI bus to cartridge memory bridge: bus layout, FSM encoding
// and the big-endian byte-lane helpers.
package pi_mem_bridge_pkg;

  localparam int BW_PI_BUS   = 45;

  localparam int PI_AOUT_LSB = 0;
  localparam int PI_DOUT_LSB = 32;
  localparam int PI_OE       = 40;
  localparam int PI_WE       = 41;
  localparam int PI_ACT      = 42;
  localparam int PI_SPI_CLK  = 43;
  localparam int PI_SYNC     = 44;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  // Big-endian lanes: byte address bit 0 clear selects the high half [15:8].
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_WORD = 2'b11;

  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lo);
    return lo ? word[7:0] : word[15:8];
  endfunction

  function automatic logic [1:0] lane_be(input logic lo);
    return lo ? BE_LO : BE_HI;
  endfunction

endpackage

// File: rtl/pi_mem_bridge_rd_cache.sv
// One-word read cache for pi_mem_bridge (module pi_rd_cache).
// Only compiled and instantiated when PI_RD_CACHE_EN is defined.
`ifdef PI_RD_CACHE_EN
module pi_rd_cache
  import pi_mem_bridge_pkg::*;
#(
  parameter int ADDR_W = 23
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic              lookup_lane,
  output logic              hit,
  output logic [7:0]        hit_byte,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [15:0]       fill_word,
  input  logic              inval_en,
  input  logic [ADDR_W-1:0] inval_addr,
  input  logic              flush
);

  logic              valid;
  logic [ADDR_W-1:0] tag;
  logic [15:0]       word;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      word  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (fill_en) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      word  <= fill_word;
    end else if (inval_en && inval_addr == tag) begin
      valid <= 1'b0;
    end
  end

  assign hit      = valid && (lookup_addr == tag);
  assign hit_byte = lane_byte(word, lookup_lane);

endmodule
`endif

// File: rtl/pi_mem_bridge.sv
// PI bus byte access to 16-bit req/ack cartridge memory bridge (sys_clk domain).
// Optional one-word read cache enabled by defining PI_RD_CACHE_EN.
module pi_mem_bridge
  import pi_mem_bridge_pkg::*;
#(
  parameter int         ADDR_W   = 23,
  parameter logic [7:0] WIN_BASE = 8'h00,
  parameter int         TMO_CYC  = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic [BW_PI_BUS-1:0] pi_bus,
  output logic [7:0]           pi_din,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [15:0]          mem_wdata,
  output logic [1:0]           mem_be,
  input  logic                 mem_ack,
  input  logic [15:0]          mem_rdata,
  output logic                 busy,
  output logic                 err_tmo,
  output logic                 err_ovr
);

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  logic        pi_sync;
  logic        pi_we;
  logic        pi_oe;
  logic [7:0]  dout;
  logic [31:0] aout;

  assign pi_sync = pi_bus[PI_SYNC];
  assign pi_we   = pi_bus[PI_WE];
  assign pi_oe   = pi_bus[PI_OE];
  assign dout    = pi_bus[PI_DOUT_LSB +: 8];
  assign aout    = pi_bus[PI_AOUT_LSB +: 32];

  logic unused_bus;
  assign unused_bus = ^{pi_bus[PI_ACT], pi_bus[PI_SPI_CLK], aout};

  logic [0:0]        state;
  logic [7:0]        tmo_cnt;
  logic              rd_lane;
  logic              strobe;
  logic              in_win;
  logic [ADDR_W-1:0] word_addr;
  logic              lane;
  logic              req_timeout;
  logic              rd_hit;
  logic [7:0]        hit_byte;

  // A sync from a non-exec phase (neither we nor oe) carries no access at all.
  assign strobe      = pi_sync && (pi_we || pi_oe);
  assign in_win      = (aout[31:24] == WIN_BASE);
  assign word_addr   = aout[ADDR_W:1];
  assign lane        = aout[0];
  assign req_timeout = (state == ST_REQ) && !mem_ack && (tmo_cnt == TMO_LAST);

  assign mem_req = (state == ST_REQ);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      rd_lane   <= 1'b0;
      pi_din    <= 8'hFF;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      err_tmo   <= 1'b0;
      err_ovr   <= 1'b0;
    end else begin
      if (strobe && state != ST_IDLE) err_ovr <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (strobe) begin
            if (!in_win) begin
              if (!pi_we) pi_din <= 8'hFF;
            end else if (!pi_we && rd_hit) begin
              pi_din <= hit_byte;
            end else begin
              state     <= ST_REQ;
              tmo_cnt   <= '0;
              mem_we    <= pi_we;
              mem_addr  <= word_addr;
              mem_wdata <= {dout, dout};
              mem_be    <= pi_we ? lane_be(lane) : BE_WORD;
              rd_lane   <= lane;
            end
          end
        end
        default: begin
          if (mem_ack) begin
            if (!mem_we) pi_din <= lane_byte(mem_rdata, rd_lane);
            state <= ST_IDLE;
          end else if (req_timeout) begin
            err_tmo <= 1'b1;
            if (!mem_we) pi_din <= 8'hFF;
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
      endcase
    end
  end

`ifdef PI_RD_CACHE_EN
  pi_rd_cache #(.ADDR_W(ADDR_W)) u_rd_cache (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .lookup_addr (word_addr),
    .lookup_lane (lane),
    .hit         (rd_hit),
    .hit_byte    (hit_byte),
    .fill_en     ((state == ST_REQ) && mem_ack && !mem_we),
    .fill_addr   (mem_addr),
    .fill_word   (mem_rdata),
    .inval_en    ((state == ST_IDLE) && strobe && in_win && pi_we),
    .inval_addr  (word_addr),
    .flush       (req_timeout)
  );
`else
  assign rd_hit   = 1'b0;
  assign hit_byte = 8'hFF;
`endif

endmodule

// File: tb/tb_pi_mem_bridge.sv
// Self-checking bench for pi_mem_bridge: vector table, hand-written corner sequences and a
// randomized run against a reference model. Define PI_RD_CACHE_EN to cover the read cache too.
module tb_pi_mem_bridge;
  import pi_mem_bridge_pkg::*;

  localparam int         ADDR_W   = 23;
  localparam logic [7:0] WIN_BASE = 8'h00;
  localparam int         TMO_CYC  = 16;
  localparam int         WIN_CYC  = TMO_CYC + 4;

  logic                 sys_clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [BW_PI_BUS-1:0] pi_bus = '0;
  logic                 mem_ack = 1'b0;
  logic [15:0]          mem_rdata = '0;
  logic [7:0]           pi_din;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [15:0]          mem_wdata;
  logic [1:0]           mem_be;
  logic                 busy;
  logic                 err_tmo;
  logic                 err_ovr;

  always #5 sys_clk = ~sys_clk;

  pi_mem_bridge #(.ADDR_W(ADDR_W), .WIN_BASE(WIN_BASE), .TMO_CYC(TMO_CYC)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .pi_bus    (pi_bus),
    .pi_din    (pi_din),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err_tmo   (err_tmo),
    .err_ovr   (err_ovr)
  );

  int total = 0;
  int bad = 0;

  // Observations collected by applyStimulus for one access window.
  int          obsReqCycles, obsReqRises, obsDone;
  bit          obsStable;
  logic [31:0] obsAddr;
  logic [1:0]  obsBe;
  logic        obsWe;
  logic [15:0] obsWdata;
  logic [7:0]  obsDinDone, obsDinBefore, obsDinFinal;

  // Reference model state: last returned byte, sticky flags and the one-word cache.
  logic [7:0]        expDin = 8'hFF;
  bit                expTmo = 1'b0;
  bit                expOvr = 1'b0;
  bit                cValid = 1'b0;
  logic [ADDR_W-1:0] cTag = '0;
  logic [15:0]       cWord = '0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    bit          we;
    bit          oe;
    logic [7:0]  data;
    int          lat;
    logic [15:0] rdata;
    int          ovr;
    int          expReq;
    logic [31:0] expAddr;
    logic [1:0]  expBe;
    logic [15:0] expWdata;
    logic [7:0]  expDin;
    bit          expTmo;
    bit          expOvr;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [BW_PI_BUS-1:0] packBus(input bit sync, input bit we, input bit oe,
                                                   input logic [7:0] data, input logic [31:0] addr);
    logic spi, act;
    spi = 1'($urandom);
    act = 1'($urandom);
    return {sync, spi, act, we, oe, data, addr};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one pi_sync strobe (cycle 0) and watches WIN_CYC cycles, acking `lat` cycles
  // after mem_req first rises (lat < 0 never acks) and optionally re-strobing at cycle ovr.
  task automatic applyStimulus(input logic [31:0] addr, input bit we, input bit oe,
                               input logic [7:0] data, input int lat, input logic [15:0] rdata,
                               input int ovr);
    int firstReq;
    bit prevReq;
    firstReq = 0;
    prevReq = 1'b0;
    obsReqCycles = 0;
    obsReqRises = 0;
    obsDone = 0;
    obsStable = 1'b1;
    obsAddr = '0;
    obsBe = '0;
    obsWe = 1'b0;
    obsWdata = '0;
    @(negedge sys_clk);
    obsDinBefore = pi_din;
    pi_bus = packBus(1'b1, we, oe, data, addr);
    mem_ack = 1'b0;
    @(posedge sys_clk);
    for (int c = 1; c <= WIN_CYC; c++) begin
      @(negedge sys_clk);
      if (mem_req) begin
        obsReqCycles++;
        if (!prevReq) begin
          obsReqRises++;
          if (firstReq == 0) begin
            firstReq = c;
            obsAddr = 32'(mem_addr);
            obsBe = mem_be;
            obsWe = mem_we;
            obsWdata = mem_wdata;
          end
        end else if (32'(mem_addr) != obsAddr || mem_be != obsBe || mem_we != obsWe ||
                     mem_wdata != obsWdata) begin
          obsStable = 1'b0;
        end
      end
      prevReq = mem_req;
      if (obsDone == 0 && !busy) begin
        obsDone = c;
        obsDinDone = pi_din;
      end
      if (obsDone == 0) obsDinBefore = pi_din;
      pi_bus = (c == ovr) ? packBus(1'b1, 1'b0, 1'b1, 8'h99, 32'h0000_0004)
                          : packBus(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), $urandom);
      mem_ack = mem_req && firstReq > 0 && lat >= 0 && (c - firstReq) == lat;
      mem_rdata = mem_ack ? rdata : 16'($urandom);
    end
    @(negedge sys_clk);
    mem_ack = 1'b0;
    pi_bus = packBus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    obsDinFinal = pi_din;
  endtask

  task automatic checkAccess(input string name, input int expReq, input logic [31:0] eAddr,
                             input logic [1:0] eBe, input bit eWe, input logic [15:0] eWdata,
                             input logic [7:0] eDin, input logic [7:0] prevDin,
                             input bit eTmo, input bit eOvr);
    checkOutput({name, " req_cycles"}, 32'(obsReqCycles), 32'(expReq));
    checkOutput({name, " req_rises"}, 32'(obsReqRises), (expReq > 0) ? 32'd1 : 32'd0);
    if (expReq > 0) begin
      checkOutput({name, " mem_addr"}, obsAddr, eAddr);
      checkOutput({name, " mem_be"}, 32'(obsBe), 32'(eBe));
      checkOutput({name, " mem_we"}, 32'(obsWe), 32'(eWe));
      if (eWe) checkOutput({name, " mem_wdata"}, 32'(obsWdata), 32'(eWdata));
      checkOutput({name, " req_stable"}, 32'(obsStable), 32'd1);
      checkOutput({name, " din_held"}, 32'(obsDinBefore), 32'(prevDin));
    end
    checkOutput({name, " done_cycle"}, 32'(obsDone), (expReq > 0) ? 32'(expReq + 1) : 32'd1);
    checkOutput({name, " din_at_done"}, 32'(obsDinDone), 32'(eDin));
    checkOutput({name, " din_final"}, 32'(obsDinFinal), 32'(eDin));
    checkOutput({name, " err_tmo"}, 32'(err_tmo), 32'(eTmo));
    checkOutput({name, " err_ovr"}, 32'(err_ovr), 32'(eOvr));
  endtask

  // Predicts one access from the bridge's rules, updates the model, then runs and checks it.
  task automatic modelAccess(input string name, input logic [31:0] addr, input bit we,
                             input bit oe, input logic [7:0] data, input int lat,
                             input logic [15:0] rdata, input bit wantOvr);
    bit exec, inwin, hit, mem, ok;
    logic [ADDR_W-1:0] wa;
    int expReq, ovrCyc;
    logic [7:0] prevDin;
    exec = we || oe;
    inwin = (addr[31:24] == WIN_BASE);
    wa = addr[ADDR_W:1];
    hit = 1'b0;
`ifdef PI_RD_CACHE_EN
    hit = exec && inwin && !we && cValid && (cTag == wa);
`endif
    mem = exec && inwin && !hit;
    ok = (lat >= 0) && (lat < TMO_CYC);
    expReq = !mem ? 0 : (ok ? lat + 1 : TMO_CYC);
    ovrCyc = (mem && wantOvr) ? int'($urandom_range(1, expReq)) : 0;
    prevDin = expDin;
    if (exec && !we) begin
      if (!inwin || (mem && !ok)) expDin = 8'hFF;
      else if (hit) expDin = 8'(cWord >> (addr[0] ? 0 : 8));
      else expDin = 8'(rdata >> (addr[0] ? 0 : 8));
    end
    if (mem && !ok) expTmo = 1'b1;
    if (ovrCyc > 0) expOvr = 1'b1;
    if (mem && we && cTag == wa) cValid = 1'b0;
    if (mem && !we && ok) begin
      cValid = 1'b1;
      cTag = wa;
      cWord = rdata;
    end
    if (mem && !ok) cValid = 1'b0;
    applyStimulus(addr, we, oe, data, lat, rdata, ovrCyc);
    checkAccess(name, expReq, 32'(wa), we ? (addr[0] ? 2'b01 : 2'b10) : 2'b11, we,
                {data, data}, expDin, prevDin, expTmo, expOvr);
  endtask

  initial begin
    vecs[0] = '{"rd_win",  32'h0000_0005, 1'b0, 1'b1, 8'h00,  2, 16'hA55A, 0,
                3,  32'h2,  2'b11, 16'h0000, 8'h5A, 1'b0, 1'b0};
    vecs[1] = '{"wr_hi",   32'h0000_0010, 1'b1, 1'b0, 8'h3C,  4, 16'h0000, 0,
                5,  32'h8,  2'b10, 16'h3C3C, 8'h5A, 1'b0, 1'b0};
    vecs[2] = '{"rd_oow",  32'h0100_0000, 1'b0, 1'b1, 8'h00,  0, 16'hA55A, 0,
                0,  32'h0,  2'b00, 16'h0000, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{"rd_tmo",  32'h0000_0020, 1'b0, 1'b1, 8'h00, -1, 16'h0000, 0,
                16, 32'h10, 2'b11, 16'h0000, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{"rd_min",  32'h0000_0007, 1'b0, 1'b1, 8'h00,  0, 16'h1234, 0,
                1,  32'h3,  2'b11, 16'h0000, 8'h34, 1'b1, 1'b0};
    vecs[5] = '{"wr_last", 32'h0000_0000, 1'b1, 1'b1, 8'hC3, 15, 16'h0000, 0,
                16, 32'h0,  2'b10, 16'hC3C3, 8'h34, 1'b1, 1'b0};
    vecs[6] = '{"rd_ovr",  32'h0000_0009, 1'b0, 1'b1, 8'h00,  2, 16'hBEEF, 2,
                3,  32'h4,  2'b11, 16'h0000, 8'hEF, 1'b1, 1'b1};
    vecs[7] = '{"nonexec", 32'h0000_0004, 1'b0, 1'b0, 8'h55,  0, 16'h0000, 0,
                0,  32'h0,  2'b00, 16'h0000, 8'hEF, 1'b1, 1'b1};
    vecs[8] = '{"wr_oow",  32'h0200_0011, 1'b1, 1'b0, 8'h77,  0, 16'h0000, 0,
                0,  32'h0,  2'b00, 16'h0000, 8'hEF, 1'b1, 1'b1};
    vecs[9] = '{"wr_lo",   32'h0000_0021, 1'b1, 1'b0, 8'hA7,  1, 16'h0000, 0,
                2,  32'h10, 2'b01, 16'hA7A7, 8'hEF, 1'b1, 1'b1};

    // Reset held over a few edges, with a strobe present that must be ignored.
    rst_n = 1'b0;
    pi_bus = packBus(1'b1, 1'b0, 1'b1, 8'h12, 32'h0000_0002);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checkOutput("reset pi_din", 32'(pi_din), 32'hFF);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("reset mem_be", 32'(mem_be), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset err_tmo", 32'(err_tmo), 32'd0);
    checkOutput("reset err_ovr", 32'(err_ovr), 32'd0);
    pi_bus = packBus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      logic [7:0] prev;
      prev = expDin;
      applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].oe, vecs[i].data, vecs[i].lat,
                    vecs[i].rdata, vecs[i].ovr);
      checkAccess(vecs[i].name, vecs[i].expReq, vecs[i].expAddr, vecs[i].expBe, vecs[i].we,
                  vecs[i].expWdata, vecs[i].expDin, prev, vecs[i].expTmo, vecs[i].expOvr);
      expDin = vecs[i].expDin;
      expTmo = vecs[i].expTmo;
      expOvr = vecs[i].expOvr;
    end

    // Reset while a request is outstanding: request withdrawn, sticky flags cleared.
    @(negedge sys_clk);
    pi_bus = packBus(1'b1, 1'b0, 1'b1, 8'h00, 32'h0000_0006);
    @(posedge sys_clk);
    @(negedge sys_clk);
    pi_bus = packBus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("rst_mid req_before", 32'(mem_req), 32'd1);
    @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    checkOutput("rst_mid mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mid busy", 32'(busy), 32'd0);
    checkOutput("rst_mid pi_din", 32'(pi_din), 32'hFF);
    checkOutput("rst_mid mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mid err_tmo", 32'(err_tmo), 32'd0);
    checkOutput("rst_mid err_ovr", 32'(err_ovr), 32'd0);
    rst_n = 1'b1;
    expDin = 8'hFF;
    expTmo = 1'b0;
    expOvr = 1'b0;
    cValid = 1'b0;

    modelAccess("post_rst", 32'h0000_0006, 1'b0, 1'b1, 8'h00, 1, 16'h0F1E, 1'b0);

`ifdef PI_RD_CACHE_EN
    modelAccess("cache_fill", 32'h0000_0004, 1'b0, 1'b1, 8'h00, 1, 16'h1122, 1'b0);
    modelAccess("cache_hit",  32'h0000_0005, 1'b0, 1'b1, 8'h00, 1, 16'hDEAD, 1'b0);
    modelAccess("cache_wr",   32'h0000_0004, 1'b1, 1'b0, 8'h66, 0, 16'h0000, 1'b0);
    modelAccess("cache_miss", 32'h0000_0005, 1'b0, 1'b1, 8'h00, 2, 16'h6611, 1'b0);
`endif

    for (int i = 0; i < 120; i++) begin
      logic [31:0] a;
      bit w, o;
      int lat, r;
      r = int'($urandom_range(0, 9));
      a = {(r == 0) ? 8'($urandom_range(1, 255)) : WIN_BASE,
           (r == 1) ? 16'($urandom) : 16'h0000, 8'($urandom_range(0, 15))};
      r = int'($urandom_range(0, 9));
      w = (r == 1) || (r >= 6);
      o = (r >= 1) && (r < 6 || r == 1);
      r = int'($urandom_range(0, 9));
      if (r == 0) lat = -1;
      else if (r == 1) lat = int'($urandom_range(TMO_CYC - 1, TMO_CYC + 2));
      else lat = int'($urandom_range(0, 4));
      modelAccess("rand", a, w, o, 8'($urandom), lat, 16'($urandom),
                  ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
